// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word addresses to a registered instruction memory
// and buffers responses in a 2-entry in-order FIFO feeding decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        halted
);

    localparam logic [31:0] DEPTH    = 32'(MEM_DEPTH);
    localparam logic [31:0] START_PC = RESET_PC % DEPTH;

    typedef enum logic {FETCH, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [1:0]  count_q, count_d;

    logic        deq;
    logic        enq;
    logic        issue;
    logic [1:0]  occupancy;
    logic [1:0]  wrPos;

    assign mem_addr = fetch_pc_q;
    assign if_valid = (count_q != 2'd0);
    assign if_inst  = head_inst_q;
    assign if_pc    = head_pc_q;
    assign halted   = (state_q == HALT);

    // Occupancy counts the FIFO after this cycle's dequeue plus the response still
    // owed by memory, so an issue never outruns the two FIFO slots.
    always_comb begin
        deq       = if_valid && if_ready;
        enq       = inflight_q && !redirect_en;
        occupancy = count_q - {1'b0, deq} + {1'b0, inflight_q};
        issue     = (state_q == FETCH) && !halt_req && !redirect_en && (occupancy < 2'd2);
        wrPos     = count_q - {1'b0, deq};
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_pc_d     = head_pc_q;
        head_inst_d   = head_inst_q;
        tail_pc_d     = tail_pc_q;
        tail_inst_d   = tail_inst_q;
        count_d       = count_q - {1'b0, deq} + {1'b0, enq};

        case (state_q)
            FETCH: if (halt_req && !redirect_en) state_d = HALT;
            HALT:  if (redirect_en) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        if (issue) begin
            fetch_pc_d    = (fetch_pc_q == DEPTH - 32'd1) ? 32'd0 : fetch_pc_q + 32'd1;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end

        if (deq) begin
            head_pc_d   = tail_pc_q;
            head_inst_d = tail_inst_q;
        end

        if (enq) begin
            if (wrPos == 2'd0) begin
                head_pc_d   = inflight_pc_q;
                head_inst_d = mem_inst;
            end else begin
                tail_pc_d   = inflight_pc_q;
                tail_inst_d = mem_inst;
            end
        end

        // A redirect flushes everything buffered or owed; the response for the
        // in-flight request is dropped because inflight is cleared here.
        if (redirect_en) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc % DEPTH;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            head_pc_q     <= 32'd0;
            head_inst_q   <= 32'd0;
            tail_pc_q     <= 32'd0;
            tail_inst_q   <= 32'd0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_pc_q     <= head_pc_d;
            head_inst_q   <= head_inst_d;
            tail_pc_q     <= tail_pc_d;
            tail_inst_q   <= tail_inst_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory word k holds 0x1000_0000+k, and every decode
// transfer is checked in order against a queue of expected PCs.
module tb_inst_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst = 32'd0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        halted;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned expPc[$];

    inst_fetch #(.RESET_PC(32'd0), .MEM_DEPTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_inst    (mem_inst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // Registered instruction memory: data for an address appears the next cycle.
    always @(posedge clock) mem_inst <= 32'h1000_0000 + mem_addr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic rdEn,
                                 input logic [31:0] rdPc, input logic hlt);
        @(posedge clock);
        #1;
        reset       = rst;
        if_ready    = rdy;
        redirect_en = rdEn;
        redirect_pc = rdPc;
        halt_req    = hlt;
    endtask

    task automatic pushRange(input int unsigned first, input int unsigned count);
        for (int i = 0; i < int'(count); i++) expPc.push_back((first + i) % 32);
    endtask

    task automatic waitFor(input bit onAddr, input logic [31:0] value, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clock);
            n++;
            hit = onAddr ? (mem_addr == value) : (if_valid && if_pc == value);
        end
        checkOutput(tag, {31'd0, hit}, 32'd1);
    endtask

    // Every accepted transfer must match the head of the expected queue.
    task automatic monitorTransfers();
        int unsigned pc;
        forever begin
            @(negedge clock);
            if (!reset && if_valid && if_ready) begin
                if (expPc.size() == 0) begin
                    checkOutput("unexpected_xfer_pc", if_pc, 32'hFFFF_FFFF);
                end else begin
                    pc = expPc.pop_front();
                    checkOutput("xfer_pc", if_pc, pc);
                    checkOutput("xfer_inst", if_inst, 32'h1000_0000 + pc);
                end
            end
        end
    endtask

    initial begin
        fork
            monitorTransfers();
        join_none

        // Reset values
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_inst", if_inst, 32'd0);
        checkOutput("rst_pc", if_pc, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);

        // Sequential fetch: if_valid rises two cycles after reset release
        pushRange(0, 8);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("lat_c0_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("lat_c0_addr", mem_addr, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("lat_c1_valid", {31'd0, if_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("lat_c2_valid", {31'd0, if_valid}, 32'd1);

        // Backpressure for five cycles with PC 3 at the head
        waitFor(0, 32'd2, "wait_pc2");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            @(negedge clock);
            checkOutput("stall_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("stall_pc", if_pc, 32'd3);
            checkOutput("stall_inst", if_inst, 32'h1000_0003);
            checkOutput("stall_addr", mem_addr, 32'd5);
        end
        applyStimulus(0, 1, 0, 0, 0);

        // Redirect to 20 while PC 7 is transferred
        waitFor(0, 32'd6, "wait_pc6");
        pushRange(20, 3);
        applyStimulus(0, 1, 1, 32'd20, 0);
        @(negedge clock);
        checkOutput("redir_accept_pc", if_pc, 32'd7);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("post_redir_valid", {31'd0, if_valid}, 32'd0);

        // Redirect to 30 and wrap through the end of memory
        waitFor(0, 32'd21, "wait_pc21");
        expPc.push_back(30);
        expPc.push_back(31);
        expPc.push_back(0);
        expPc.push_back(1);
        applyStimulus(0, 1, 1, 32'd30, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Out-of-range redirect target folds modulo depth: 37 -> 5
        waitFor(0, 32'd0, "wait_pc0_wrap");
        pushRange(5, 5);
        applyStimulus(0, 1, 1, 32'd37, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Halt pulse while address 10 is presented
        waitFor(1, 32'd9, "wait_addr9");
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge clock);
        checkOutput("halt_addr", mem_addr, 32'd10);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_addr_held", mem_addr, 32'd10);
        checkOutput("halt_drained_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("halt_drained_queue", 32'(expPc.size()), 32'd0);

        // Redirect out of halt
        pushRange(2, 2);
        applyStimulus(0, 1, 1, 32'd2, 0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("unhalt", {31'd0, halted}, 32'd0);

        // Fill the FIFO, then reset mid-operation
        waitFor(0, 32'd3, "wait_pc3");
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("pre_reset_pc", if_pc, 32'd4);
        pushRange(0, 3);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("post_reset_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("post_reset_addr", mem_addr, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("post_reset_c1_valid", {31'd0, if_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("post_reset_c2_valid", {31'd0, if_valid}, 32'd1);
        waitFor(0, 32'd2, "wait_pc2_after_reset");
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("final_queue", 32'(expPc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
